// File: rtl/proc_pkg.sv
// proc_pkg: shared widths, beat field offsets, FSM states and row-table reset constants
package proc_pkg;
  localparam int COORD_W = 11;
  localparam int MAX_EDGES = 30;
  localparam int CNT_W = 5;
  localparam int HDR_FLAG = 31;
  localparam int FID_LSB = 23;
  localparam int CNT_LSB = 18;
  localparam int ROW_BASE = 120;
  localparam int ROW_STEP = 80;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  function automatic logic [31:0] beat(input logic hdr, input logic [7:0] fid,
                                       input logic [CNT_W-1:0] cnt, input logic [COORD_W-1:0] v);
    beat = '0;
    beat[HDR_FLAG] = hdr;
    beat[FID_LSB +: 8] = fid;
    beat[CNT_LSB +: CNT_W] = cnt;
    beat[COORD_W-1:0] = v;
  endfunction
endpackage

// File: rtl/edge_row_table.sv
// edge_row_table: programmable row table, entry i resets to 120 + 80*i
//   clk/reset: clock, async active-high reset
//   i_we/i_widx/i_wdata: write port; i_ridx/o_rdata: combinational read port
module edge_row_table #(
  parameter int NUM_ROWS = 4,
  parameter int COORD_W = proc_pkg::COORD_W,
  localparam int IDX_W = $clog2(NUM_ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_widx,
  input  logic [COORD_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]   i_ridx,
  output logic [COORD_W-1:0] o_rdata
);
  import proc_pkg::*;
  logic [COORD_W-1:0] r_tab [NUM_ROWS];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_ROWS; i++) r_tab[i] <= COORD_W'(ROW_BASE + ROW_STEP * i);
    else if (i_we) r_tab[i_widx] <= i_wdata;
  assign o_rdata = r_tab[i_ridx];
endmodule

// File: rtl/edge_scan_scheduler.sv
// edge_scan_scheduler: steps the measured row per frame and streams the previous frame's edge list
//   sop/enable: frame start and scheduler on/off; measured_list: packed edge x positions
//   cfg_we/cfg_idx/cfg_row/cfg_num_rows: row-table programming and active entry count
//   edge_row: row to measure; out_valid/out_ready/out_data/out_last: report stream
//   drop_cnt: saturating overrun count; frame_id: captured frame count
module edge_scan_scheduler #(
  parameter int NUM_ROWS = 4,
  parameter int MAX_EDGES = proc_pkg::MAX_EDGES,
  parameter int COORD_W = proc_pkg::COORD_W,
  localparam int IDX_W = $clog2(NUM_ROWS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sop,
  input  logic [MAX_EDGES*COORD_W-1:0] measured_list,
  input  logic                         enable,
  input  logic                         cfg_we,
  input  logic [IDX_W-1:0]             cfg_idx,
  input  logic [COORD_W-1:0]           cfg_row,
  input  logic [IDX_W:0]               cfg_num_rows,
  output logic [COORD_W-1:0]           edge_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic [7:0]                   drop_cnt,
  output logic [7:0]                   frame_id
);
  import proc_pkg::*;
  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_armed;
  logic [COORD_W-1:0] r_list [MAX_EDGES];
  logic [CNT_W-1:0]   r_cnt, r_idx, w_cnt;
  logic [IDX_W:0]     w_num;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [COORD_W-1:0] w_row;
  logic               w_zero, w_adv, w_cap, w_drop, w_hs;
  always_comb begin
    w_num = cfg_num_rows == '0 ? (IDX_W+1)'(1) :
            cfg_num_rows > (IDX_W+1)'(NUM_ROWS) ? (IDX_W+1)'(NUM_ROWS) : cfg_num_rows;
    w_ptr_nxt = ({1'b0, r_ptr} + (IDX_W+1)'(1) >= w_num) ? '0 : r_ptr + IDX_W'(1);
    // count stops at the first zero entry; later entries are stale
    w_cnt = '0;
    w_zero = 1'b0;
    for (int k = 0; k < MAX_EDGES; k++) begin
      w_zero = w_zero | (measured_list[k*COORD_W +: COORD_W] == '0);
      w_cnt = w_cnt + CNT_W'(!w_zero);
    end
    w_adv = sop & enable;
    w_cap = w_adv & r_armed & (r_state == IDLE);
    w_drop = w_adv & r_armed & (r_state != IDLE);
    w_hs = out_valid & out_ready;
  end
  // table read uses the pre-write value, so a same-cycle write lands on the next visit
  edge_row_table #(.NUM_ROWS(NUM_ROWS), .COORD_W(COORD_W)) u_tab (
    .clk(clk), .reset(reset), .i_we(cfg_we), .i_widx(cfg_idx), .i_wdata(cfg_row),
    .i_ridx(w_ptr_nxt), .o_rdata(w_row)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_armed <= 1'b0;
      r_cnt <= '0;
      r_idx <= '0;
      for (int k = 0; k < MAX_EDGES; k++) r_list[k] <= '0;
      edge_row <= COORD_W'(ROW_BASE);
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      drop_cnt <= '0;
      frame_id <= '0;
    end else begin
      if (w_adv) begin
        r_ptr <= w_ptr_nxt;
        edge_row <= w_row;
      end
      // first sop after reset or enable rising has no measured row behind it
      r_armed <= enable & (r_armed | sop);
      if (w_drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (r_state == IDLE) begin
        if (w_cap) begin
          for (int k = 0; k < MAX_EDGES; k++) r_list[k] <= measured_list[k*COORD_W +: COORD_W];
          r_cnt <= w_cnt;
          r_idx <= '0;
          frame_id <= frame_id + 8'd1;
          out_valid <= 1'b1;
          out_last <= w_cnt == '0;
          out_data <= beat(1'b1, frame_id + 8'd1, w_cnt, edge_row);
          r_state <= HDR;
        end
      end else if (w_hs) begin
        if (out_last) begin
          r_state <= IDLE;
          out_valid <= 1'b0;
          out_last <= 1'b0;
          out_data <= '0;
        end else begin
          r_state <= DATA;
          out_data <= beat(1'b0, 8'd0, r_idx, r_list[r_idx]);
          out_last <= r_idx == r_cnt - CNT_W'(1);
          r_idx <= r_idx + CNT_W'(1);
        end
      end
    end
endmodule

// File: tb/tb_edge_scan_scheduler.sv
// tb_edge_scan_scheduler: scoreboard bench for edge_scan_scheduler
module tb_edge_scan_scheduler;
  logic clk = 1'b0, reset = 1'b1, sop = 1'b0, enable = 1'b0, cfg_we = 1'b0, out_ready;
  logic [329:0] measured_list = '0;
  logic [1:0] cfg_idx = '0;
  logic [10:0] cfg_row = '0, edge_row;
  logic [2:0] cfg_num_rows = 3'd4;
  logic out_valid, out_last;
  logic [31:0] out_data;
  logic [7:0] drop_cnt, frame_id;
  edge_scan_scheduler dut (
    .clk(clk), .reset(reset), .sop(sop), .measured_list(measured_list), .enable(enable),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_row(cfg_row), .cfg_num_rows(cfg_num_rows),
    .edge_row(edge_row), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .drop_cnt(drop_cnt), .frame_id(frame_id)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, mode = 0, ph = 0;
  logic [32:0] q[$];
  logic [10:0] lst [30];
  logic [10:0] m_tab [4];
  logic [10:0] m_row;
  logic [7:0] m_fid, m_drop;
  int m_ptr, m_n;
  logic m_en, m_armed;
  logic stall = 1'b0;
  logic [32:0] prev;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_tab[i] = 11'(120 + 80 * i);
    m_row = 11'd120; m_fid = '0; m_drop = '0; m_ptr = 0; m_armed = 1'b0;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_list(input int n, input int base);
    for (int k = 0; k < 30; k++) lst[k] = k < n ? 11'(base + 13 * k + 1) : 11'd0;
  endtask
  task automatic do_sop();
    int c, ne;
    logic z;
    c = 0; z = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (lst[k] == 0) z = 1'b1;
      else if (!z) c++;
    end
    if (m_en) begin
      if (m_armed && q.size() == 0) begin
        m_fid++;
        q.push_back({1'(c == 0), 1'b1, m_fid, 5'(c), 7'd0, m_row});
        for (int k = 0; k < c; k++) q.push_back({1'(k == c - 1), 1'b0, 8'd0, 5'(k), 7'd0, lst[k]});
      end else if (m_armed && m_drop != 8'hff) m_drop++;
      m_armed = 1'b1;
      ne = m_n == 0 ? 1 : (m_n > 4 ? 4 : m_n);
      m_ptr = m_ptr + 1 >= ne ? 0 : m_ptr + 1;
      m_row = m_tab[m_ptr];
    end
    for (int k = 0; k < 30; k++) measured_list[k*11 +: 11] = lst[k];
    sop = 1'b1;
    tick(1);
    sop = 1'b0;
    chk("edge_row", edge_row, m_row);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("frame_id", frame_id, m_fid);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) tick(1);
    chk("drain", q.size(), 0);
  endtask
  task automatic do_cfg(input int idx, input int row);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_row = 11'(row);
    m_tab[idx] = 11'(row);
    tick(1);
    cfg_we = 1'b0;
  endtask
  task automatic set_en(input logic e);
    enable = e; m_en = e;
    if (!e) m_armed = 1'b0;
  endtask
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (ph == 1 || ph == 2 ? 1'b0 : 1'b1) : 1'b0;
      ph = (ph + 1) % 4;
    end
  end
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (stall) chk("hold", {out_last, out_data}, prev);
      if (out_ready) begin
        if (q.size() == 0) chk("extra_beat", {out_last, out_data}, 0);
        else chk("beat", {out_last, out_data}, q.pop_front());
        stall = 1'b0;
      end else begin
        stall = 1'b1;
        prev = {out_last, out_data};
      end
    end else stall = 1'b0;
  end
  initial begin
    model_reset();
    m_en = 1'b0; m_n = 4;
    tick(3);
    chk("rst_edge_row", edge_row, 120);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_out", {out_last, out_data}, 0);
    chk("rst_frame_id", frame_id, 0);
    reset = 1'b0;
    tick(1);
    cfg_num_rows = 3'd3; m_n = 3;
    set_en(1'b1);
    tick(1);
    set_list(0, 0);
    lst[0] = 11'd100; lst[1] = 11'd250; lst[2] = 11'd400;
    for (int i = 0; i < 4; i++) begin
      do_sop();
      tick(1000);
    end
    drain();
    mode = 1;
    set_list(5, 300);
    do_sop();
    drain();
    mode = 2;
    set_list(2, 500);
    do_sop();
    tick(5);
    set_list(6, 900);
    do_sop();
    tick(3);
    mode = 0;
    drain();
    do_cfg(1, 333);
    set_list(0, 0);
    for (int i = 0; i < 3; i++) begin
      do_sop();
      drain();
    end
    set_list(30, 50);
    do_sop();
    drain();
    cfg_num_rows = 3'd0; m_n = 0;
    set_list(2, 20);
    do_sop();
    drain();
    cfg_num_rows = 3'd7; m_n = 7;
    for (int i = 0; i < 5; i++) begin
      set_list(i + 1, 100 * i);
      do_sop();
      drain();
    end
    mode = 1;
    set_list(4, 700);
    do_sop();
    tick(2);
    set_en(1'b0);
    drain();
    do_sop();
    set_en(1'b1);
    tick(1);
    do_sop();
    do_sop();
    drain();
    mode = 2;
    set_list(3, 1000);
    do_sop();
    tick(3);
    chk("valid_before_reset", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("valid_in_reset", out_valid, 0);
    q.delete();
    model_reset();
    tick(2);
    reset = 1'b0;
    mode = 0;
    tick(1);
    chk("post_rst_edge_row", edge_row, 120);
    chk("post_rst_drop_cnt", drop_cnt, 0);
    chk("post_rst_frame_id", frame_id, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_scan_scheduler.md
# edge_scan_scheduler

Controller for the `processing` edge-measurement datapath. It picks which image row `processing` measures each frame by stepping through a programmable row table and driving `edge_row`. At every frame boundary it snapshots the previous frame's `measured_list` and streams it out as a header beat plus one beat per edge, over a valid/ready handshake, to the rover message path.

## Interface
Parameters:
- `NUM_ROWS`, 4: depth of the row table. Power of two, 2..16.
- `MAX_EDGES`, 30: entries in `measured_list`.
- `COORD_W`, 11: coordinate width.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `sop` in 1: frame start, the same pulse that `processing` sees.
- `measured_list` in `MAX_EDGES`×`COORD_W`: edge x positions from `processing`.
- `enable` in 1: scheduler on/off.
- `cfg_we` in 1: row-table write strobe.
- `cfg_idx` in log2(`NUM_ROWS`): row-table write address.
- `cfg_row` in `COORD_W`: row value to write.
- `cfg_num_rows` in log2(`NUM_ROWS`)+1: number of active table entries.
- `edge_row` out `COORD_W`: row that `processing` measures.
- `out_valid` out 1: output beat is valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out 32: header or data beat.
- `out_last` out 1: final beat of the current report.
- `drop_cnt` out 8: saturating count of frames dropped.
- `frame_id` out 8: frames captured, wraps at 256.

## Operation
- **Row table reset values:** entry i = 120 + 80·i.
- **Writes:** a write at `cfg_idx` takes effect at once in the table. `edge_row` only changes on a `sop`.
- **Active entry count:** `cfg_num_rows` of 0 is treated as 1. Values above `NUM_ROWS` are treated as `NUM_ROWS`.
- **Row pointer:** `ptr` resets to 0. On each `sop` while `enable`=1, `ptr` advances by 1 and wraps to 0 when it reaches the active count. `edge_row` is then loaded with table[new `ptr`]. While `enable`=0, `edge_row` holds its value.
- **Snapshot:** taken on the `sop` cycle, before `processing` clears the list. The block captures all `measured_list` entries, plus `cap_row` = the `edge_row` value in force during the frame just ended.
- **Edge count:** count = number of leading non-zero entries, 0..30. Entries at or after the first zero are ignored.
- **FSM states:** IDLE, HDR, DATA.
  - IDLE: on `sop` with `enable`=1, capture the snapshot, increment `frame_id`, go to HDR. Skip capture for the first `sop` after reset or after `enable` rises, because no row has been measured yet.
  - HDR: drive the header beat. `out_last`=1 if count=0. On handshake, go to DATA if count>0, otherwise to IDLE.
  - DATA: beat k carries entry k. `out_last`=1 on beat count−1. On the last handshake, go to IDLE.
- **Header beat:** `out_data[31]`=1, `[30:23]`=`frame_id`, `[22:18]`=count, `[10:0]`=`cap_row`. All other bits 0.
- **Data beat:** `out_data[31]`=0, `[22:18]`=index, `[10:0]`=x. All other bits 0.
- **`sop` during HDR/DATA (overrun):** the current report continues unchanged and the new frame's data is discarded. `drop_cnt` increments and saturates at 255. `ptr` and `edge_row` still advance.
- **`enable` falling mid-report:** the current report completes. No new captures follow.
- **`reset` mid-report:** `out_valid` drops immediately.
- **Reset values:** `edge_row`=120, `out_valid`=0, `out_last`=0, `out_data`=0, `drop_cnt`=0, `frame_id`=0, state IDLE, `ptr`=0.

## Timing
- `edge_row` is registered and updates on the clock edge that samples `sop`. It is valid from the cycle after `sop`.
- `out_valid` for the header rises 1 cycle after `sop`.
- Beat k+1 is presented the cycle after beat k's handshake. With `out_ready` held at 1, a report takes count+1 consecutive cycles.
- A handshake occurs when `out_valid` and `out_ready` are both 1 on a clock edge.
- Once `out_valid` is raised it holds until the handshake. `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- `sop` on the same cycle as the final handshake: the final beat completes, the state goes to IDLE, and that `sop` counts as overrun. A new capture needs IDLE at the `sop` cycle.
- `cfg_we` on the same cycle as `sop` for the entry being loaded: the old value is loaded into `edge_row` and the new value applies from the next wrap.

## Structure
- Package `proc_pkg` holds:
  - `COORD_W`, `MAX_EDGES`;
  - header/data field offsets;
  - the FSM state enum;
  - the row-table reset formula constants.
- Sub-module `edge_row_table` holds the table registers: write port, read port, reset initialisation.
- Everything else lives in `edge_scan_scheduler`.

## Test plan
- **Reset values:** after reset, `edge_row`=120, `out_valid`=0, `drop_cnt`=0.
- **Row stepping:** `enable`=1 and four `sop` pulses, 1000 cycles apart, with `cfg_num_rows`=3 → `edge_row` sequence 200, 280, 120, 200.
- **Normal report:** list = {100, 250, 400, 0, …} at `sop`, `out_ready`=1 → header count=3 with `cap_row` equal to the row in force for that frame, then data x = 100, 250, 400, with `out_last` on the 4th beat.
- **Backpressure:** `out_ready` toggling 1,0,0,1 → each beat holds steady until accepted, order is unchanged, and no beat is duplicated.
- **Overrun:** `out_ready`=0 across the next `sop` → `drop_cnt`=1, the report in progress is intact, and `edge_row` still advances.
- **Table write and corner inputs:**
  - `cfg_we` idx 1 = 333 → value appears at the next visit to entry 1.
  - All-zero list → single header beat, count=0, `out_last`=1.
  - 30 full entries → 31 beats in total.
